// File: rtl/sha1_host_pkg.sv
// sha1_host_pkg: shared widths, types and SHA-1 constants for the SHA-1
// host controller and the core top.
// No ports. Helper hash_word() selects word idx (0 = h0 = bits 159:128).
package sha1_host_pkg;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 16;
  localparam int HASH_WORDS      = 5;
  localparam int BLOCK_W         = 512;
  localparam int HASH_W          = 160;

  // SHA-1 initial chaining values, shared with the core top.
  localparam logic [31:0] H0 = 32'h67452301;
  localparam logic [31:0] H1 = 32'hEFCDAB89;
  localparam logic [31:0] H2 = 32'h98BADCFE;
  localparam logic [31:0] H3 = 32'h10325476;
  localparam logic [31:0] H4 = 32'hC3D2E1F0;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [HASH_W-1:0]  hash_t;

  function automatic word_t hash_word(input hash_t h, input logic [2:0] idx);
    return h[HASH_W-1-WORD_W*int'(idx) -: WORD_W];
  endfunction
endpackage

// File: rtl/sha1_host_ctrl_if.sv
// sha1_host_ctrl_if: bundles the word input stream, the SHA-1 core
// start/msg/busy/ready/hash interface, the digest output stream and status.
// Modports: master = host controller, slave = environment (source, core, sink).
//
// Stream handshake (in_* and out_*): a word transfers on a cycle where
// valid & ready are both 1. Once valid is raised, data/last stay stable and
// valid stays high until the transfer; ready may change freely and never
// depends combinationally on valid.
interface sha1_host_ctrl_if;
  import sha1_host_pkg::*;

  word_t      in_data;
  logic       in_valid;
  logic       in_ready;

  logic       core_start;
  block_t     core_msg;
  logic       core_busy;
  logic       core_ready;
  hash_t      core_hash;

  word_t      out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  logic [2:0] pending;
  logic       err;

  modport master (
    input  in_data, in_valid, core_busy, core_ready, core_hash, out_ready,
    output in_ready, core_start, core_msg, out_data, out_valid, out_last,
    output pending, err
  );

  modport slave (
    output in_data, in_valid, core_busy, core_ready, core_hash, out_ready,
    input  in_ready, core_start, core_msg, out_data, out_valid, out_last,
    input  pending, err
  );
endinterface

// File: rtl/sha1_hash_fifo.sv
// sha1_hash_fifo: synchronous DEPTH x 160 digest FIFO with a registered head.
// Ports: clk, reset_n (async active-low), push/din write, pop removes head,
// dout = head entry, count = occupancy, empty = (count == 0).
// Entries shift toward slot 0 on pop, so dout is always a flop output.
module sha1_hash_fifo
  import sha1_host_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  hash_t            din,
  output hash_t            dout,
  output logic [CNT_W-1:0] count,
  output logic             empty
);
  hash_t            r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;
  logic [CNT_W-1:0] w_wr_pos;

  assign w_do_pop  = pop & (r_count != '0);
  assign w_do_push = push & ((int'(r_count) != DEPTH) | w_do_pop);
  // Write slot is computed after the shift of a simultaneous pop.
  assign w_wr_pos  = w_do_pop ? (r_count - CNT_W'(1)) : r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_count <= '0;
    end else begin
      if (w_do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
      end
      if (w_do_push) r_mem[w_wr_pos[IDX_W-1:0]] <= din;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[0];
  assign count = r_count;
  assign empty = (r_count == '0);
endmodule

// File: rtl/sha1_host_ctrl.sv
// sha1_host_ctrl: host-side initiator for the SHA-1 core. Packs 32-bit words
// into 512-bit blocks (first word -> msg[511:480]), issues a block when the
// core is idle and a digest slot is guaranteed, captures digests into a FIFO
// and streams each back as 5 words (h0 first, out_last on the 5th).
// Ports: clk, reset_n (async active-low), bus (sha1_host_ctrl_if.master).
// Optional macro SHA1_HOST_TIMEOUT_EN: watchdog on outstanding blocks that
// raises sticky err, clears pending and blocks further issues.
module sha1_host_ctrl
  import sha1_host_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               clk,
  input logic               reset_n,
  sha1_host_ctrl_if.master  bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [3:0]       r_wcnt;
  logic             r_full;
  block_t           r_msg;
  logic [2:0]       r_pending;
  logic [2:0]       r_idx;

  logic             w_in_fire;
  logic             w_credit;
  logic             w_issue;
  logic             w_ret;
  logic             w_out_fire;
  logic             w_pop;
  logic             w_wd_trip;
  logic             w_err;
  logic [CNT_W-1:0] w_fifo_count;
  logic             w_fifo_empty;
  hash_t            w_head;

  assign w_in_fire = bus.in_valid & ~r_full;
  // The core cannot be stalled, so every in-flight block must already own a
  // FIFO slot: blocks outstanding plus digests buffered stay below the depth.
  assign w_credit  = (int'(r_pending) + int'(w_fifo_count)) < FIFO_DEPTH;
  assign w_issue   = r_full & ~bus.core_busy & w_credit & ~w_err & ~w_wd_trip;
  // A ready with nothing outstanding is spurious and dropped.
  assign w_ret     = bus.core_ready & (r_pending != 3'd0);

  // Block assembler.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wcnt <= 4'd0;
      r_full <= 1'b0;
      r_msg  <= '0;
    end else if (w_in_fire) begin
      r_msg[BLOCK_W-1-WORD_W*int'(r_wcnt) -: WORD_W] <= bus.in_data;
      r_wcnt <= r_wcnt + 4'd1;  // wraps to 0 after the 16th word
      if (r_wcnt == 4'(WORDS_PER_BLOCK - 1)) r_full <= 1'b1;
    end else if (w_issue) begin
      r_full <= 1'b0;
    end
  end

  // Outstanding block counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 3'd0;
    end else if (w_wd_trip) begin
      r_pending <= 3'd0;
    end else begin
      unique case ({w_issue, w_ret})
        2'b10:   r_pending <= r_pending + 3'd1;
        2'b01:   r_pending <= r_pending - 3'd1;
        default: r_pending <= r_pending;
      endcase
    end
  end

`ifdef SHA1_HOST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wdog;
  logic            r_err;

  // Fires on the cycle the counter would reach TIMEOUT_CYCLES.
  assign w_wd_trip = (r_pending != 3'd0) & ~bus.core_ready &
                     (int'(r_wdog) == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_wd_trip) r_err <= 1'b1;
      if ((r_pending == 3'd0) | bus.core_ready | w_wd_trip) r_wdog <= '0;
      else                                                  r_wdog <= r_wdog + WD_W'(1);
    end
  end

  assign w_err = r_err;
`else
  assign w_wd_trip = 1'b0;
  assign w_err     = 1'b0;
`endif

  sha1_hash_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_ret),
    .pop     (w_pop),
    .din     (bus.core_hash),
    .dout    (w_head),
    .count   (w_fifo_count),
    .empty   (w_fifo_empty)
  );

  // Serializer: r_idx walks the head digest, popping after the 5th word.
  assign w_out_fire = ~w_fifo_empty & bus.out_ready;
  assign w_pop      = w_out_fire & (r_idx == 3'(HASH_WORDS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_idx <= 3'd0;
    else if (w_pop)     r_idx <= 3'd0;
    else if (w_out_fire) r_idx <= r_idx + 3'd1;
  end

  assign bus.in_ready   = ~r_full;
  assign bus.core_start = w_issue;
  assign bus.core_msg   = r_msg;
  assign bus.out_valid  = ~w_fifo_empty;
  assign bus.out_data   = hash_word(w_head, r_idx);
  assign bus.out_last   = ~w_fifo_empty & (r_idx == 3'(HASH_WORDS - 1));
  assign bus.pending    = r_pending;
  assign bus.err        = w_err;
endmodule

// File: tb/tb_sha1_host_ctrl.sv
`timescale 1ns/1ps
module tb_sha1_host_ctrl;
  import sha1_host_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
  localparam logic [159:0] ABC_DIG = 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sha1_host_ctrl_if bus();

  sha1_host_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // staged inputs, applied on the falling edge by step()
  bit          d_in_valid = 0;
  logic [31:0] d_in_data = '0;
  bit          d_out_ready = 0;
  bit          d_core_busy = 0;
  bit          d_force_ready = 0;
  int          ready_mode = 0;   // 0 fixed, 1 alternate, 2 random
  bit          auto_core = 1;
  int          core_lat = 3;
  int          gap_max = 0;
  bit          chk_pend = 1;

  // reference model state
  logic [511:0] exp_msg_q[$];   // completed blocks awaiting issue, in order
  logic [31:0]  exp_q[$];       // expected digest words, in issue order
  logic [511:0] core_q[$];      // core model: accepted blocks
  int           core_due[$];
  logic [511:0] cur_blk;
  int cur_n, cyc, n_starts, n_returned, n_popped, n_out_words, pend_model, out_pos, max_pend;
  bit held;
  logic [31:0] held_data;
  logic held_last;
  bit s_start, s_in_acc, lat_chk;

  // Stand-in digest: the real SHA-1 value for "abc", otherwise a cheap mix.
  function automatic logic [159:0] hash_fn(input logic [511:0] m);
    if (m == ABC_BLK) return ABC_DIG;
    return {m[511:480] ^ m[351:320], m[479:448] + m[31:0], m[447:416] ^ 32'h5a5a5a5a,
            m[415:384] ^ m[63:32], m[383:352] + m[95:64]};
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[511-32*k -: 32] = $urandom();
    return b;
  endfunction

  task automatic model_clear();
    exp_msg_q.delete(); exp_q.delete(); core_q.delete(); core_due.delete();
    cur_n = 0; n_starts = 0; n_returned = 0; n_popped = 0; pend_model = 0;
    out_pos = 0; held = 0; lat_chk = 0;
  endtask

  // One clock cycle: drive at negedge, sample and score 2 ns later.
  task automatic step();
    logic [159:0] h;
    logic [159:0] dig;
    bit rdy;
    int buffered;
    @(negedge clk);
    if (ready_mode == 1)      d_out_ready = ~d_out_ready;
    else if (ready_mode == 2) d_out_ready = ($urandom_range(0, 1) == 1);
    bus.in_valid  = d_in_valid;
    bus.in_data   = d_in_data;
    bus.out_ready = d_out_ready;
    bus.core_busy = d_core_busy;
    h = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    rdy = d_force_ready || (auto_core && core_q.size() > 0 && cyc >= core_due[0]);
    if (rdy && core_q.size() > 0) begin
      h = hash_fn(core_q.pop_front());
      void'(core_due.pop_front());
    end
    bus.core_ready = rdy;
    bus.core_hash  = h;
    d_force_ready  = 0;
    #2;
    cyc++;
    if (int'(bus.pending) > max_pend) max_pend = int'(bus.pending);
    if (chk_pend) check_val("pending", 512'(bus.pending), 512'(pend_model));
    if (lat_chk) check_val("out_valid_latency", 512'(bus.out_valid), 512'(1));
    if (held) begin
      check_val("hold_valid", 512'(bus.out_valid), 512'(1));
      check_val("hold_data", 512'(bus.out_data), 512'(held_data));
      check_val("hold_last", 512'(bus.out_last), 512'(held_last));
    end
    held = bus.out_valid && !bus.out_ready;
    held_data = bus.out_data;
    held_last = bus.out_last;
    // input word acceptance
    s_in_acc = bus.in_valid && bus.in_ready;
    if (s_in_acc) begin
      cur_blk[511-32*cur_n -: 32] = bus.in_data;
      cur_n++;
      if (cur_n == 16) begin exp_msg_q.push_back(cur_blk); cur_n = 0; end
    end
    // block issue
    s_start = bus.core_start;
    if (s_start) begin
      check_val("credit", 512'((n_starts - n_popped) < DEPTH), 512'(1));
      if (exp_msg_q.size() == 0) check_val("unexpected_start", 512'(1), 512'(0));
      else begin
        check_val("core_msg", bus.core_msg, exp_msg_q[0]);
        dig = hash_fn(exp_msg_q.pop_front());
        for (int i = 0; i < 5; i++) exp_q.push_back(dig[159-32*i -: 32]);
      end
      core_q.push_back(bus.core_msg);
      core_due.push_back(cyc + core_lat);
      n_starts++;
    end
    // digest return (ignored while nothing is outstanding)
    lat_chk = 0;
    if (rdy && pend_model > 0) begin
      buffered = n_returned - n_popped;
      lat_chk = (buffered == 0);
      n_returned++;
    end
    pend_model = pend_model + (s_start ? 1 : 0) - ((rdy && pend_model > 0) ? 1 : 0);
    // output words
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check_val("unexpected_out", 512'(bus.out_data), 512'(0));
      else check_val("out_data", 512'(bus.out_data), 512'(exp_q.pop_front()));
      check_val("out_last", 512'(bus.out_last), 512'(out_pos == 4));
      n_out_words++;
      if (out_pos == 4) begin out_pos = 0; n_popped++; end
      else out_pos++;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_word(input logic [31:0] w);
    int budget = 400;
    repeat ($urandom_range(0, gap_max)) step();
    d_in_valid = 1;
    d_in_data  = w;
    do begin step(); budget--; end while (!s_in_acc && budget > 0);
    if (!s_in_acc) check_val("in_accept_timeout", 512'(0), 512'(1));
    d_in_valid = 0;
    d_in_data  = $urandom();
  endtask

  task automatic send_block(input logic [511:0] b);
    for (int k = 0; k < 16; k++) send_word(b[511-32*k -: 32]);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || exp_msg_q.size() > 0 || pend_model > 0 || cur_n != 0)
           && n < budget) begin
      step(); n++;
    end
    check_val("idle_reached", 512'(n < budget), 512'(1));
  endtask

  task automatic do_reset();
    reset_n = 0;
    d_in_valid = 0; d_force_ready = 0; d_core_busy = 0; ready_mode = 0;
    model_clear();
    step();
    model_clear();
    step();
    reset_n = 1;
  endtask

  // ---------------- main ----------------
  initial begin
    int base, viol, k;
    cyc = 0; n_out_words = 0; max_pend = 0;
    model_clear();
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    bus.core_busy = 0; bus.core_ready = 0; bus.core_hash = '0;
    reset_n = 0;
    step();
    step();
    // reset state
    check_val("rst_in_ready",   512'(bus.in_ready),   512'(1));
    check_val("rst_core_start", 512'(bus.core_start), 512'(0));
    check_val("rst_core_msg",   bus.core_msg,         512'(0));
    check_val("rst_out_valid",  512'(bus.out_valid),  512'(0));
    check_val("rst_out_last",   512'(bus.out_last),   512'(0));
    check_val("rst_out_data",   512'(bus.out_data),   512'(0));
    check_val("rst_pending",    512'(bus.pending),    512'(0));
    check_val("rst_err",        512'(bus.err),        512'(0));
    reset_n = 1;
    step();

    // 1: "abc" block
    auto_core = 1; core_lat = 3; d_out_ready = 1;
    base = n_out_words;
    send_block(ABC_BLK);
    wait_idle(200);
    check_val("t1_starts", 512'(n_starts), 512'(1));
    check_val("t1_words",  512'(n_out_words - base), 512'(5));

    // 2: back-pressure, credits run out at 4
    core_lat = 20; d_out_ready = 0; max_pend = 0;
    base = n_starts;
    for (int b = 0; b < 5; b++) send_block(rand_block());
    repeat (100) step();
    check_val("t2_starts_held", 512'(n_starts - base), 512'(4));
    check_val("t2_in_ready",    512'(bus.in_ready), 512'(0));
    check_val("t2_out_valid",   512'(bus.out_valid), 512'(1));
    check_val("t2_max_pend",    512'(max_pend <= 4), 512'(1));
    k = n_out_words;
    d_out_ready = 1;
    send_block(rand_block());
    wait_idle(800);
    check_val("t2_starts_all", 512'(n_starts - base), 512'(6));
    check_val("t2_words",      512'(n_out_words - k), 512'(30));

    // 3: core busy holds a full block
    core_lat = 5;
    d_core_busy = 1;
    send_block(rand_block());
    viol = 0;
    repeat (50) begin
      step();
      if (s_start || bus.in_ready) viol++;
    end
    check_val("t3_busy_hold", 512'(viol), 512'(0));
    d_core_busy = 0;
    step();
    check_val("t3_start_on_release", 512'(s_start), 512'(1));
    step();
    check_val("t3_in_ready_next", 512'(bus.in_ready), 512'(1));
    wait_idle(200);

    // 4: start coincident with ready; spurious ready
    auto_core = 0;
    send_block(rand_block());
    send_block(rand_block());
    step();
    d_core_busy = 1;
    send_block(rand_block());
    repeat (3) step();
    check_val("t4_pend_before", 512'(bus.pending), 512'(2));
    d_core_busy = 0;
    d_force_ready = 1;
    step();
    check_val("t4_coincident_start", 512'(s_start), 512'(1));
    step();
    check_val("t4_pend_after", 512'(bus.pending), 512'(2));
    repeat (2) begin d_force_ready = 1; step(); step(); end
    wait_idle(200);
    d_force_ready = 1;
    step();
    viol = 0;
    repeat (4) begin step(); if (bus.out_valid) viol++; end
    check_val("t4_spurious_no_push", 512'(viol), 512'(0));
    check_val("t4_spurious_pending", 512'(bus.pending), 512'(0));

    // 5: alternating then random out_ready, random gaps and latencies
    auto_core = 1;
    ready_mode = 1;
    base = n_popped;
    for (int b = 0; b < 3; b++) begin
      core_lat = $urandom_range(1, 30);
      send_block(rand_block());
    end
    wait_idle(2000);
    check_val("t5_digests", 512'(n_popped - base), 512'(3));
    ready_mode = 2; gap_max = 2;
    for (int b = 0; b < 4; b++) begin
      core_lat = $urandom_range(1, 40);
      send_block(rand_block());
    end
    wait_idle(3000);
    gap_max = 0; ready_mode = 0; d_out_ready = 1;
    check_val("t5_word_total", 512'(n_out_words), 512'(5 * n_popped));

`ifdef SHA1_HOST_TIMEOUT_EN
    // 6: watchdog
    chk_pend = 0; auto_core = 0;
    send_block(rand_block());
    k = 0;
    do begin step(); k++; end while (!s_start && k < 5);
    check_val("t6_started", 512'(s_start), 512'(1));
    k = 0;
    do begin step(); k++; end while (!bus.err && k < 40);
    check_val("t6_err_latency", 512'(k >= 16 && k <= 17), 512'(1));
    check_val("t6_pending_cleared", 512'(bus.pending), 512'(0));
    send_block(rand_block());
    viol = 0;
    repeat (40) begin step(); if (s_start) viol++; end
    check_val("t6_no_issue", 512'(viol), 512'(0));
    reset_n = 0;
    step();
    check_val("t6_err_reset", 512'(bus.err), 512'(0));
    do_reset();
    chk_pend = 1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
